uc_cuenta1_seq: RTL and testbench

//  Hard-wired sequencer for the ones-counter datapath: shift register Q (Valor), accumulator A, +1 adder.

---
 rtl/uc_cuenta1_seq_pkg.sv | 21 ++
 rtl/uc_cuenta1_seq_cont_iter.sv | 44 ++++
 rtl/uc_cuenta1_seq.sv | 115 +++++++++++
 tb/tb_uc_cuenta1_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uc_cuenta1_seq_pkg.sv
// Shared definitions for the ones-counter sequencer.
//   - state encodings of the control FSM (IDLE=0, LOAD=1, STEP=2, DONE=3)
//   - default iteration count / Valor width
//   - width helper for the iteration counter
package uc_cuenta1_seq_pkg;

   localparam int unsigned NDefault = 3;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StStep = 2'd2,
      StDone = 2'd3
   } state_e;

   // Counter must be able to hold 0..N; it wraps to N after the last STEP.
   function automatic int unsigned iter_width(int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/uc_cuenta1_seq_cont_iter.sv
// Iteration counter for the ones-counter sequencer.
// Up-counter with synchronous clear (priority over enable), count enable,
// asynchronous active-low reset and a terminal-count flag at N-1.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous reset, active low
//   clr_i   synchronous clear to 0
//   en_i    count enable
//   tc_o    high while the count equals N-1
module uc_cuenta1_seq_cont_iter
   import uc_cuenta1_seq_pkg::*;
#(
   parameter int unsigned N = NDefault,
   parameter int unsigned W = iter_width(N)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == W'(N - 1));

endmodule

// File: rtl/uc_cuenta1_seq.sv
// Hard-wired sequencer for the ones-counter datapath (regQ shift register,
// regA accumulator, +1 adder). A start request becomes one LOAD cycle and N
// STEP cycles (add-if-Q0, shift); completion is flagged on fin until start
// drops. The block owns no data.
// Build option: define EARLY_EXIT_EN to leave STEP as soon as regQ is zero
// (qz=1); otherwise qz is ignored and exactly N STEP cycles run.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   start      operation request, level, held until fin is seen
//   q0         LSB of regQ
//   qz         regQ == 0 (early-exit build only)
//   CargaQ     load Valor into regQ (LOAD)
//   DesplazaQ  shift regQ right (STEP)
//   ResetA     synchronous clear of regA (LOAD)
//   CargaA     load A+1 into regA (STEP, follows q0)
//   busy       high in LOAD and STEP
//   fin        high in DONE
module uc_cuenta1_seq
   import uc_cuenta1_seq_pkg::*;
#(
   parameter int unsigned N = NDefault
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic q0,
   input  logic qz,
   output logic CargaQ,
   output logic DesplazaQ,
   output logic ResetA,
   output logic CargaA,
   output logic busy,
   output logic fin
);

   state_e state_q, state_d;
   logic   it_clr, it_en, it_tc;

   uc_cuenta1_seq_cont_iter #(
      .N(N),
      .W(iter_width(N))
   ) u_cont_iter (
      .clk_i (clk),
      .rst_ni(reset),
      .clr_i (it_clr),
      .en_i  (it_en),
      .tc_o  (it_tc)
   );

`ifndef EARLY_EXIT_EN
   logic unused_qz;
   assign unused_qz = qz;
`endif

   // Outputs decode from the state register only (plus q0 in STEP), so an
   // asynchronous reset forces every strobe low in the same cycle.
   always_comb begin
      state_d   = state_q;
      CargaQ    = 1'b0;
      DesplazaQ = 1'b0;
      ResetA    = 1'b0;
      CargaA    = 1'b0;
      busy      = 1'b0;
      fin       = 1'b0;
      it_clr    = 1'b0;
      it_en     = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) state_d = StLoad;
         end
         StLoad: begin
            CargaQ  = 1'b1;
            ResetA  = 1'b1;
            busy    = 1'b1;
            it_clr  = 1'b1;
            state_d = StStep;
         end
         StStep: begin
            busy = 1'b1;
`ifdef EARLY_EXIT_EN
            if (qz) begin
               // No ones left: finish without touching regQ, regA or the count.
               state_d = StDone;
            end else begin
               DesplazaQ = 1'b1;
               CargaA    = q0;
               it_en     = 1'b1;
               if (it_tc) state_d = StDone;
            end
`else
            DesplazaQ = 1'b1;
            CargaA    = q0;
            it_en     = 1'b1;
            if (it_tc) state_d = StDone;
`endif
         end
         StDone: begin
            fin = 1'b1;
            // Requester must drop start before another run can begin.
            if (!start) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_uc_cuenta1_seq.sv
module tb_uc_cuenta1_seq;

   localparam int N = 3;

   logic clk, reset, start, q0, qz;
   logic CargaQ, DesplazaQ, ResetA, CargaA, busy, fin;

   // Datapath attached to the sequencer: regQ, regA with +1 adder.
   logic [N-1:0] valor, regQ;
   logic [3:0]   regA;

   typedef struct {
      int cnt;
      int fin_cyc;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   uc_cuenta1_seq #(.N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .q0       (q0),
      .qz       (qz),
      .CargaQ   (CargaQ),
      .DesplazaQ(DesplazaQ),
      .ResetA   (ResetA),
      .CargaA   (CargaA),
      .busy     (busy),
      .fin      (fin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (CargaQ) regQ <= valor;
      else if (DesplazaQ) regQ <= regQ >> 1;
      if (ResetA) regA <= 4'd0;
      else if (CargaA) regA <= regA + 4'd1;
   end

   assign q0 = regQ[0];
   assign qz = (regQ == '0);

   function automatic int popcnt(input logic [N-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < N; i++) if (v[i]) c++;
      return c;
   endfunction

   function automatic int exp_steps(input logic [N-1:0] v);
`ifdef EARLY_EXIT_EN
      int msb;
      if (v == '0) return 1;
      msb = 0;
      for (int i = 0; i < N; i++) if (v[i]) msb = i;
      return (msb + 2 > N) ? N : msb + 2;
`else
      return N;
`endif
   endfunction

   // Drive one operation; cycle 0 is the edge that samples start=1.
   task automatic run_op(input logic [N-1:0] v, input int hold, input bit toggle,
                         input int abort_cyc);
      exp_t e, got;
      int c, s;
      bit seen, early;
      logic [5:0] exp_v, act_v;
      @(negedge clk);
      valor = v;
      start = 1'b1;
      e.cnt = popcnt(v);
      e.fin_cyc = 2 + exp_steps(v);
      sb.push_back(e);
      c = 0;
      seen = 1'b0;
      while (!seen && c < 20) begin
         @(negedge clk);
         c++;
         if (c == abort_cyc) begin
            reset = 1'b0;
            start = 1'b0;
            #1;
            n_checks++;
            if ({CargaQ, DesplazaQ, ResetA, CargaA, busy, fin} !== 6'b0) begin
               n_fail++;
               $display("FAIL reset_mid_step: outputs %b, required 000000",
                        {CargaQ, DesplazaQ, ResetA, CargaA, busy, fin});
            end
            void'(sb.pop_back());
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({CargaQ, DesplazaQ, ResetA, CargaA, busy, fin} !== 6'b0) begin
               n_fail++;
               $display("FAIL idle_after_abort: outputs %b, required 000000",
                        {CargaQ, DesplazaQ, ResetA, CargaA, busy, fin});
            end
            return;
         end
         // Expected {CargaQ, DesplazaQ, ResetA, CargaA, busy, fin} from valor alone.
         exp_v = 6'b0;
         if (c == 1) begin
            exp_v = 6'b101010;
         end else if (c < e.fin_cyc) begin
            s = c - 2;
            early = 1'b0;
`ifdef EARLY_EXIT_EN
            early = ((v >> s) == '0);
`endif
            exp_v[1] = 1'b1;
            if (!early) begin
               exp_v[4] = 1'b1;
               exp_v[2] = v[s];
            end
         end else if (c == e.fin_cyc) begin
            exp_v[0] = 1'b1;
         end
         act_v = {CargaQ, DesplazaQ, ResetA, CargaA, busy, fin};
         n_checks++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL strobes v=%b cycle %0d: got %b, required %b", v, c, act_v, exp_v);
         end
         if (fin === 1'b1) begin
            seen = 1'b1;
            got = sb.pop_front();
            n_checks++;
            if (c != got.fin_cyc) begin
               n_fail++;
               $display("FAIL fin_latency v=%b: got cycle %0d, required %0d", v, c, got.fin_cyc);
            end
            n_checks++;
            if (regA !== 4'(got.cnt)) begin
               n_fail++;
               $display("FAIL cuenta v=%b: got %0d, required %0d", v, regA, got.cnt);
            end
            start = (hold > 0);
         end else if (toggle && c >= 1) begin
            start = 1'($urandom_range(0, 1));
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL fin_timeout v=%b: got no fin in %0d cycles, required cycle %0d",
                  v, c, e.fin_cyc);
         void'(sb.pop_front());
         start = 1'b0;
         return;
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         n_checks++;
         if ({fin, busy, CargaQ, ResetA} !== 4'b1000) begin
            n_fail++;
            $display("FAIL done_hold %0d: fin/busy/CargaQ/ResetA %b, required 1000",
                     h, {fin, busy, CargaQ, ResetA});
         end
         if (h == hold - 1) start = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if ({CargaQ, DesplazaQ, ResetA, CargaA, busy, fin} !== 6'b0) begin
         n_fail++;
         $display("FAIL idle_after_done v=%b: outputs %b, required 000000", v,
                  {CargaQ, DesplazaQ, ResetA, CargaA, busy, fin});
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      valor = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({CargaQ, DesplazaQ, ResetA, CargaA, busy, fin} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_state: outputs %b, required 000000",
                  {CargaQ, DesplazaQ, ResetA, CargaA, busy, fin});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({CargaQ, DesplazaQ, ResetA, CargaA, busy, fin} !== 6'b0) begin
         n_fail++;
         $display("FAIL idle_no_start: outputs %b, required 000000",
                  {CargaQ, DesplazaQ, ResetA, CargaA, busy, fin});
      end
   endtask

   task automatic test_patterns();
      logic [N-1:0] pats [6];
      pats = '{3'b101, 3'b111, 3'b000, 3'b001, 3'b110, 3'b100};
      foreach (pats[i]) run_op(pats[i], 0, 1'b0, 0);
   endtask

   task automatic test_hold_done();
      run_op(3'b011, 4, 1'b0, 0);
   endtask

   task automatic test_start_toggle();
      for (int i = 0; i < 4; i++) run_op(3'(i * 3 + 1), 0, 1'b1, 0);
   endtask

   task automatic test_reset_mid_step();
      run_op(3'b111, 0, 1'b0, 3);
      run_op(3'b110, 0, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) run_op(3'(i), 0, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_hold_done();
      test_start_toggle();
      test_reset_mid_step();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
